// File: rtl/nn_accuracy_monitor.sv
// Accuracy scoreboard for the NN classifier: compares each scored result against a
// loadable ground-truth label memory and keeps global and per-class correct/total counts.
module nn_accuracy_monitor #(
  parameter int unsigned NUM_SAMPLES = 750,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LABEL_W     = 8,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CNT_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lbl_wr_en,
  input  logic [ADDR_W-1:0]  lbl_wr_addr,
  input  logic [LABEL_W-1:0] lbl_wr_data,
  input  logic               start,
  input  logic               batch_done,
  input  logic [LABEL_W-1:0] result,
  input  logic [LABEL_W-1:0] class_sel,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   total_cnt,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [CNT_W-1:0]   class_total,
  output logic [CNT_W-1:0]   class_correct,
  output logic               range_err
);

  localparam int unsigned IdxW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [ADDR_W-1:0]  LastIdx     = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W:0]    NumSampExt  = (ADDR_W + 1)'(NUM_SAMPLES);
  localparam logic [LABEL_W-1:0] NumClassesL = LABEL_W'(NUM_CLASSES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic               bd_q;
  logic               busy_q;
  logic               done_q;
  logic               range_err_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [CNT_W-1:0]   total_q;
  logic [CNT_W-1:0]   correct_q;
  logic [CNT_W-1:0]   cls_total_q   [NUM_CLASSES];
  logic [CNT_W-1:0]   cls_correct_q [NUM_CLASSES];
  logic [LABEL_W-1:0] mem           [NUM_SAMPLES];

  logic               score;
  logic               wr_ok;
  logic               match;
  logic               out_of_range;
  logic [LABEL_W-1:0] rd_lbl;

  always_comb begin
    score  = batch_done && !bd_q && (state_q == StRun) && !start;
    wr_ok  = lbl_wr_en && (state_q != StRun) && ({1'b0, lbl_wr_addr} < NumSampExt);
    rd_lbl = '0;
    if ({1'b0, idx_q} < NumSampExt) begin
      rd_lbl = mem[idx_q[IdxW-1:0]];
    end
    match        = (result == rd_lbl);
    out_of_range = (rd_lbl >= NumClassesL) || (result >= NumClassesL);
  end

  // Label storage is deliberately not reset so a rerun after reset reuses the loaded set.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[lbl_wr_addr[IdxW-1:0]] <= lbl_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bd_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      idx_q       <= '0;
      total_q     <= '0;
      correct_q   <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        cls_total_q[c]   <= '0;
        cls_correct_q[c] <= '0;
      end
    end else begin
      bd_q <= batch_done;
      if (start) begin
        state_q     <= StRun;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        range_err_q <= 1'b0;
        idx_q       <= '0;
        total_q     <= '0;
        correct_q   <= '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
          cls_total_q[c]   <= '0;
          cls_correct_q[c] <= '0;
        end
      end else if (score) begin
        total_q <= total_q + CNT_W'(1);
        idx_q   <= idx_q + ADDR_W'(1);
        if (match) begin
          correct_q <= correct_q + CNT_W'(1);
        end
        if (out_of_range) begin
          range_err_q <= 1'b1;
        end
        // An in-range label selects exactly one class; out-of-range labels match none.
        for (int c = 0; c < NUM_CLASSES; c++) begin
          if (rd_lbl == LABEL_W'(c)) begin
            cls_total_q[c] <= cls_total_q[c] + CNT_W'(1);
            if (match) begin
              cls_correct_q[c] <= cls_correct_q[c] + CNT_W'(1);
            end
          end
        end
        if (idx_q == LastIdx) begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    class_total   = '0;
    class_correct = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (class_sel == LABEL_W'(c)) begin
        class_total   = cls_total_q[c];
        class_correct = cls_correct_q[c];
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign range_err   = range_err_q;
  assign total_cnt   = total_q;
  assign correct_cnt = correct_q;

endmodule

// File: tb/tb_nn_accuracy_monitor.sv
// Directed self-checking bench for nn_accuracy_monitor with a 4-sample evaluation run.
module tb_nn_accuracy_monitor;

  localparam int unsigned NumSamples = 4;
  localparam int unsigned NumClasses = 10;
  localparam int unsigned LabelW     = 8;
  localparam int unsigned AddrW      = 10;
  localparam int unsigned CntW       = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              lbl_wr_en = 1'b0;
  logic [AddrW-1:0]  lbl_wr_addr = '0;
  logic [LabelW-1:0] lbl_wr_data = '0;
  logic              start = 1'b0;
  logic              batch_done = 1'b0;
  logic [LabelW-1:0] result = '0;
  logic [LabelW-1:0] class_sel = '0;
  logic              busy;
  logic              done;
  logic [CntW-1:0]   total_cnt;
  logic [CntW-1:0]   correct_cnt;
  logic [CntW-1:0]   class_total;
  logic [CntW-1:0]   class_correct;
  logic              range_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  nn_accuracy_monitor #(
    .NUM_SAMPLES (NumSamples),
    .NUM_CLASSES (NumClasses),
    .LABEL_W     (LabelW),
    .ADDR_W      (AddrW),
    .CNT_W       (CntW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lbl_wr_en     (lbl_wr_en),
    .lbl_wr_addr   (lbl_wr_addr),
    .lbl_wr_data   (lbl_wr_data),
    .start         (start),
    .batch_done    (batch_done),
    .result        (result),
    .class_sel     (class_sel),
    .busy          (busy),
    .done          (done),
    .total_cnt     (total_cnt),
    .correct_cnt   (correct_cnt),
    .class_total   (class_total),
    .class_correct (class_correct),
    .range_err     (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lbl(input int unsigned addr, input int unsigned data);
    lbl_wr_en   = 1'b1;
    lbl_wr_addr = AddrW'(addr);
    lbl_wr_data = LabelW'(data);
    tick();
    lbl_wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One-cycle batch_done, then one idle cycle so the next pulse is a fresh rising edge.
  task automatic score(input int unsigned res);
    result     = LabelW'(res);
    batch_done = 1'b1;
    tick();
    batch_done = 1'b0;
    tick();
  endtask

  task automatic class_check(input string tag, input int unsigned sel,
                             input int unsigned exp_tot, input int unsigned exp_cor);
    class_sel = LabelW'(sel);
    #1;
    check({tag, "_total"}, 32'(class_total), 32'(exp_tot));
    check({tag, "_correct"}, 32'(class_correct), 32'(exp_cor));
  endtask

  initial begin
    // Reset and idle behaviour.
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_total", 32'(total_cnt), 0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) score(1);
    check("idle_total", 32'(total_cnt), 0);
    check("idle_correct", 32'(correct_cnt), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);

    // Basic run; the write to address 4 is out of range and must not alias onto a label.
    write_lbl(0, 3);
    write_lbl(1, 1);
    write_lbl(2, 4);
    write_lbl(3, 1);
    write_lbl(4, 5);
    pulse_start();
    check("run_busy", 32'(busy), 1);
    score(3);
    score(2);
    score(4);
    result     = 8'd1;
    batch_done = 1'b1;
    tick();
    batch_done = 1'b0;
    check("basic_done_edge", 32'(done), 1);
    check("basic_total", 32'(total_cnt), 4);
    check("basic_correct", 32'(correct_cnt), 3);
    check("basic_busy", 32'(busy), 0);
    check("basic_range", 32'(range_err), 0);
    class_check("basic_c1", 1, 2, 1);
    class_check("basic_c3", 3, 1, 1);
    class_check("basic_c2", 2, 0, 0);
    tick();
    score(7);
    check("done_ignore", 32'(total_cnt), 4);

    // Level hold counts once.
    pulse_start();
    result     = 8'd3;
    batch_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("hold_total", 32'(total_cnt), 1);
    check("hold_correct", 32'(correct_cnt), 1);
    batch_done = 1'b0;
    tick();
    score(1);
    check("hold_rise_total", 32'(total_cnt), 2);

    // Write lockout during RUN, then restart; an event coincident with start is dropped.
    write_lbl(2, 9);
    start      = 1'b1;
    batch_done = 1'b1;
    result     = 8'd3;
    tick();
    start      = 1'b0;
    batch_done = 1'b0;
    tick();
    check("restart_total", 32'(total_cnt), 0);
    check("restart_busy", 32'(busy), 1);
    check("restart_done", 32'(done), 0);
    score(3);
    score(1);
    score(4);
    score(1);
    check("rerun_total", 32'(total_cnt), 4);
    check("rerun_correct", 32'(correct_cnt), 4);
    check("rerun_done", 32'(done), 1);
    class_check("rerun_c4", 4, 1, 1);

    // Range error: label 12 matched by result 12.
    write_lbl(0, 12);
    pulse_start();
    score(12);
    check("range_total", 32'(total_cnt), 1);
    check("range_correct", 32'(correct_cnt), 1);
    check("range_err", 32'(range_err), 1);
    class_check("range_c12", 12, 0, 0);
    class_check("range_c3", 3, 0, 0);
    score(1);
    score(4);
    score(1);
    check("range_sticky", 32'(range_err), 1);
    write_lbl(0, 3);

    // Asynchronous reset mid-run, then identical rerun.
    pulse_start();
    check("pre_rst_range", 32'(range_err), 0);
    score(3);
    score(2);
    check("pre_rst_total", 32'(total_cnt), 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_total", 32'(total_cnt), 0);
    check("async_correct", 32'(correct_cnt), 0);
    check("async_busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    tick();
    score(3);
    check("post_rst_idle", 32'(total_cnt), 0);
    pulse_start();
    score(3);
    score(2);
    score(4);
    score(1);
    check("final_total", 32'(total_cnt), 4);
    check("final_correct", 32'(correct_cnt), 3);
    check("final_done", 32'(done), 1);
    class_check("final_c1", 1, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_accuracy_monitor.md
Name: nn_accuracy_monitor

Overview:
- Synthesizable accuracy scoreboard for the neural network classifier core.
- Holds a loadable ground-truth label memory and watches the classifier's per-sample result and batch_done strobe.
- Keeps global and per-class correct/total counts and signals completion after NUM_SAMPLES samples.
- Sits beside the NN top so accuracy can be read on-chip or by the bench without simulation-only counting.

Parameters:
- NUM_SAMPLES, 750, number of samples in one evaluation run / label memory depth
- NUM_CLASSES, 10, number of output classes
- LABEL_W, 8, width of label and result values
- ADDR_W, 10, label memory address width; must satisfy 2^ADDR_W >= NUM_SAMPLES
- CNT_W, 10, counter width; must satisfy 2^CNT_W > NUM_SAMPLES

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- lbl_wr_en  in  1  label memory write strobe
- lbl_wr_addr  in  ADDR_W  label write address
- lbl_wr_data  in  LABEL_W  label value
- start  in  1  single-cycle pulse: clear counters, begin run
- batch_done  in  1  classifier sample-complete level/strobe
- result  in  LABEL_W  classifier output class, valid while batch_done=1
- class_sel  in  LABEL_W  class index for per-class readout
- busy  out  1  run in progress
- done  out  1  run complete, sticky until next start or reset
- total_cnt  out  CNT_W  samples scored this run
- correct_cnt  out  CNT_W  samples with result == label
- class_total  out  CNT_W  samples whose label == class_sel
- class_correct  out  CNT_W  correct samples whose label == class_sel
- range_err  out  1  sticky: a result or label was >= NUM_CLASSES

Behaviour:
- Reset (rst=0, async): FSM=IDLE; busy=0, done=0, range_err=0; total_cnt, correct_cnt and all per-class counters = 0; batch_done_q=0; sample index=0. Label memory contents are not reset.
- FSM states:
  - IDLE: start -> RUN.
  - RUN: busy=1; a score event with index == NUM_SAMPLES-1 -> DONE.
  - DONE: done=1; start -> RUN.
- start in any state: clears all counters, index=0, done=0, range_err=0; next state RUN. start in RUN restarts the run; a score event in that same cycle is discarded.
- Score event: rising edge of batch_done, i.e. batch_done=1 and batch_done_q=0 in RUN. A held-high batch_done counts once. batch_done_q is registered every cycle in every state.
- On a score event, at the same clock edge:
  - lbl = mem[index].
  - total_cnt +1.
  - If result == lbl: correct_cnt +1.
  - If lbl < NUM_CLASSES: class_total[lbl] +1, and class_correct[lbl] +1 when matched.
  - If lbl >= NUM_CLASSES or result >= NUM_CLASSES: range_err=1; the sample still counts in total_cnt and is counted correct only if equal.
  - index +1.
- Counters are visible one cycle after the event edge (registered outputs).
- Score events in IDLE or DONE are ignored and change no counter.
- Label memory: single write port plus an asynchronous read at index. Writes are accepted only in IDLE or DONE; lbl_wr_en in RUN is ignored. Writes with lbl_wr_addr >= NUM_SAMPLES are ignored.
- Readout: class_total and class_correct are combinational muxes on class_sel; class_sel >= NUM_CLASSES returns 0.
- No counter can wrap: the maximum value is NUM_SAMPLES, which is < 2^CNT_W.
- Reset mid-run aborts immediately. A new start is required after reset.

Test Plan:
- Reset/idle: hold rst=0 then release; pulse batch_done 3 times with no start -> all counts 0, busy=0, done=0.
- Basic run:
  - Stimulus: NUM_SAMPLES=4; load labels {3,1,4,1}; start; results {3,2,4,1}, each with a 1-cycle batch_done.
  - Required: total_cnt=4, correct_cnt=3, done=1 the cycle after the 4th event.
  - Required: class_sel=1 -> class_total=2, class_correct=1.
- Level hold: batch_done held high 5 cycles with result=label -> total_cnt +1 only; counts again only after batch_done drops and rises.
- Range error:
  - Stimulus: label 12 with NUM_CLASSES=10, result 12.
  - Required: correct_cnt +1, range_err=1, no per-class counter changes.
  - Required: class_sel=12 -> class_total=0, class_correct=0.
- Restart and write lockout:
  - Stimulus: lbl_wr_en during RUN; then start after 2 events.
  - Required: the write has no effect on memory; all counters return to 0; index restarts at 0; the full run of 4 completes normally.
- Async reset mid-run: drive rst low between clk edges after 2 events -> outputs clear immediately, without waiting for a clock edge; label memory is retained, so rerunning gives identical results.
